fwd_hazard_unit: RTL

- Parametrised successor to the pipeline forwarding unit.
- Generalises forwarding to NSRC source operands and NFWD producer stages, with a priority encoder where the youngest stage wins.
- Adds a per-register scoreboard for long-latency ops (mul/div, cache-miss loads), writeback-slot conflict detection and a single stall output.
- Sits beside the decode/execute boundary; feeds operand muxes and pipeline-enable logic.

---
 rtl/fwd_hazard_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use/scoreboard hazard detection and
// single stall output for the decode/execute boundary.
//
// Forwarding: per source operand, the youngest producer stage (index 0)
// writing the same non-zero register wins. A per-register down-counter
// scoreboard tracks long-latency writes. Decode stalls on:
//   - an unready forward source,
//   - a read of a busy register,
//   - a WAW against a busy register,
//   - a writeback-slot collision with a pending op.
module fwd_hazard_unit #(
    parameter int  NSRC = 2,
    parameter int  AW   = 5,
    parameter int  NFWD = 2,
    parameter int  CW   = 4,
    localparam int SELW = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NFWD*AW-1:0]   fwd_rd,
    input  logic [NFWD-1:0]      fwd_wr,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_wr,
    input  logic [CW-1:0]        issue_lat,
    input  logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic                 issue_ack,
    output logic                 sb_busy_any
);

    localparam int NREG = 2 ** AW;

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [NREG-1:0] busy;

    logic [AW-1:0]   op_addr;
    logic            op_hit;
    logic            op_rdy;
    logic [SELW-1:0] op_sel;
    logic            src_stall;

    logic            issue_sb;
    logic            waw_hazard;
    logic            slot_hazard;
    logic [CW:0]     lat_p1;

    // Busy flags; register 0 never has a pending write.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign sb_busy_any = |busy;

    // Per-operand forward select (youngest stage first) and read hazards.
    // A busy register stalls even if some stage matches, so a stale stage
    // value is never consumed for a scoreboarded write.
    always_comb begin
        fwd_sel   = '0;
        src_stall = 1'b0;
        op_addr   = '0;
        op_hit    = 1'b0;
        op_rdy    = 1'b0;
        op_sel    = '0;
        for (int i = 0; i < NSRC; i++) begin
            op_addr = src_addr[i*AW +: AW];
            op_hit  = 1'b0;
            op_rdy  = 1'b0;
            op_sel  = '0;
            for (int k = 0; k < NFWD; k++) begin
                if (!op_hit && fwd_wr[k] && (fwd_rd[k*AW +: AW] == op_addr)
                    && (op_addr != '0)) begin
                    op_hit = 1'b1;
                    op_rdy = fwd_ready[k];
                    op_sel = SELW'(k + 1);
                end
            end
            fwd_sel[i*SELW +: SELW] = op_sel;
            if (src_valid[i] && (op_addr != '0)
                && ((op_hit && !op_rdy) || busy[op_addr])) begin
                src_stall = 1'b1;
            end
        end
    end

    // Issue-side hazards: WAW on a busy destination, and a writeback slot
    // already claimed by a pending op. lat+1 is one bit wider so the
    // maximum latency cannot wrap to 0 and match idle registers.
    always_comb begin
        issue_sb    = issue_valid & issue_wr & (issue_rd != '0) & (issue_lat != '0);
        waw_hazard  = busy[issue_rd];
        lat_p1      = {1'b0, issue_lat} + (CW + 1)'(1);
        slot_hazard = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if ({1'b0, cnt_q[r]} == lat_p1) begin
                slot_hazard = 1'b1;
            end
        end
        stall     = issue_valid & (src_stall | (issue_sb & (waw_hazard | slot_hazard)));
        issue_ack = issue_valid & ~stall;
    end

    // Scoreboard next state: flush, then accepted issue, then decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
        end
        if (issue_ack && issue_sb) begin
            cnt_d[issue_rd] = issue_lat;
        end
        cnt_d[0] = '0;
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end
    end

    // Scoreboard counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule
